// File: rtl/turbo_qpp_interleaver_if.sv
// Bit-serial handshake between the block source, the interleaver and the turbo encoder.
interface turbo_qpp_interleaver_if;
  logic data_in;
  logic in_valid;
  logic in_length;
  logic in_ready;
  logic ck;
  logic ckp;
  logic data_valid;
  logic length;

  modport master (
    output data_in,
    output in_valid,
    output in_length,
    input  in_ready,
    input  ck,
    input  ckp,
    input  data_valid,
    input  length
  );

  modport slave (
    input  data_in,
    input  in_valid,
    input  in_length,
    output in_ready,
    output ck,
    output ckp,
    output data_valid,
    output length
  );
endinterface

// File: rtl/turbo_qpp_interleaver.sv
// Ping-pong bit buffer that replays each code block as natural-order (ck) and LTE QPP
// interleaved (ckp) streams, with a fixed idle gap between blocks for trellis termination.
module turbo_qpp_interleaver #(
  parameter int unsigned K_SHORT    = 1056,
  parameter int unsigned F1_SHORT   = 17,
  parameter int unsigned F2_SHORT   = 66,
  parameter int unsigned K_LONG     = 6144,
  parameter int unsigned F1_LONG    = 263,
  parameter int unsigned F2_LONG    = 480,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned GAP_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  turbo_qpp_interleaver_if.slave bus
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   sum_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StGap
  } state_e;

  localparam addr_t KShort     = addr_t'(K_SHORT);
  localparam addr_t KLong      = addr_t'(K_LONG);
  localparam addr_t KShortLast = addr_t'(K_SHORT - 1);
  localparam addr_t KLongLast  = addr_t'(K_LONG - 1);
  localparam addr_t G0Short    = addr_t'((F1_SHORT + F2_SHORT) % K_SHORT);
  localparam addr_t G0Long     = addr_t'((F1_LONG + F2_LONG) % K_LONG);
  localparam addr_t DShort     = addr_t'((2 * F2_SHORT) % K_SHORT);
  localparam addr_t DLong      = addr_t'((2 * F2_LONG) % K_LONG);

  // Both operands are already reduced, so one conditional subtract yields (a + b) mod k.
  function automatic addr_t mod_add(input addr_t a, input addr_t b, input addr_t k);
    sum_t s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) begin
      s = s - {1'b0, k};
    end
    return s[ADDR_W-1:0];
  endfunction

  logic [K_LONG-1:0] bank_mem [2];

  logic [1:0]      full_q, full_d;
  logic [1:0]      tag_q, tag_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  addr_t           wr_cnt_q, wr_cnt_d;
  addr_t           rd_i_q, rd_i_d;
  addr_t           rd_pi_q, rd_pi_d;
  addr_t           rd_g_q, rd_g_d;
  logic [GapW-1:0] gap_q, gap_d;
  state_e          state_q, state_d;
  logic            ck_q, ck_d;
  logic            ckp_q, ckp_d;
  logic            valid_q, valid_d;
  logic            length_q, length_d;

  logic  wr_en;
  logic  wr_tag;
  logic  rd_tag;
  addr_t wr_last;
  addr_t rd_last;
  addr_t rd_k;
  addr_t rd_step;

  assign bus.in_ready = ~full_q[wr_bank_q];
  assign wr_en        = bus.in_valid & ~full_q[wr_bank_q];

  // The first bit of a block defines its length; later bits use the latched tag.
  assign wr_tag  = (wr_cnt_q == '0) ? bus.in_length : tag_q[wr_bank_q];
  assign wr_last = wr_tag ? KLongLast : KShortLast;

  assign rd_tag  = tag_q[rd_bank_q];
  assign rd_last = rd_tag ? KLongLast : KShortLast;
  assign rd_k    = rd_tag ? KLong : KShort;
  assign rd_step = rd_tag ? DLong : DShort;

  always_comb begin
    full_d    = full_q;
    tag_d     = tag_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_i_d    = rd_i_q;
    rd_pi_d   = rd_pi_q;
    rd_g_d    = rd_g_q;
    gap_d     = gap_q;
    state_d   = state_q;
    ck_d      = 1'b0;
    ckp_d     = 1'b0;
    valid_d   = 1'b0;
    length_d  = length_q;

    if (wr_en) begin
      if (wr_cnt_q == '0) begin
        tag_d[wr_bank_q] = bus.in_length;
      end
      if (wr_cnt_q == wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + addr_t'(1);
      end
    end

    // The writer never owns the bank being read (it is full), so the two full_d updates
    // always touch different bits.
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d = StRead;
          rd_i_d  = '0;
          rd_pi_d = '0;
          rd_g_d  = rd_tag ? G0Long : G0Short;
        end
      end
      StRead: begin
        ck_d     = bank_mem[rd_bank_q][rd_i_q];
        ckp_d    = bank_mem[rd_bank_q][rd_pi_q];
        valid_d  = 1'b1;
        length_d = rd_tag;
        rd_pi_d  = mod_add(rd_pi_q, rd_g_q, rd_k);
        rd_g_d   = mod_add(rd_g_q, rd_step, rd_k);
        rd_i_d   = rd_i_q + addr_t'(1);
        if (rd_i_q == rd_last) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          gap_d             = GapW'(GAP_CYCLES - 1);
          state_d           = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      bank_mem[wr_bank_q][wr_cnt_q] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      tag_q     <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_i_q    <= '0;
      rd_pi_q   <= '0;
      rd_g_q    <= '0;
      gap_q     <= '0;
      state_q   <= StIdle;
      ck_q      <= 1'b0;
      ckp_q     <= 1'b0;
      valid_q   <= 1'b0;
      length_q  <= 1'b0;
    end else begin
      full_q    <= full_d;
      tag_q     <= tag_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_i_q    <= rd_i_d;
      rd_pi_q   <= rd_pi_d;
      rd_g_q    <= rd_g_d;
      gap_q     <= gap_d;
      state_q   <= state_d;
      ck_q      <= ck_d;
      ckp_q     <= ckp_d;
      valid_q   <= valid_d;
      length_q  <= length_d;
    end
  end

  assign bus.ck         = ck_q;
  assign bus.ckp        = ckp_q;
  assign bus.data_valid = valid_q;
  assign bus.length     = length_q;

  pi_in_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == StRead) |-> (rd_pi_q <= rd_last && rd_g_q <= rd_last));

endmodule

// File: tb/tb_turbo_qpp_interleaver.sv
// Randomized bench for turbo_qpp_interleaver against a closed-form QPP reference model.
module tb_turbo_qpp_interleaver;

  localparam int K_S = 1056;
  localparam int K_L = 6144;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  turbo_qpp_interleaver_if bus ();

  turbo_qpp_interleaver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  bit wbits [K_L];

  // Reference model: every bit pushed into the DUT, plus per-block length and size.
  bit m_bits [$];
  int m_k    [$];
  bit m_len  [$];

  // Observed stream.
  bit out_ck  [$];
  bit out_ckp [$];
  bit out_len [$];
  int runs    [$];
  int gaps    [$];
  int run_cnt    = 0;
  int low_cnt    = 0;
  int stall_cnt  = 0;
  int idle_nz    = 0;
  bit seen_block = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      run_cnt    = 0;
      low_cnt    = 0;
      seen_block = 1'b0;
    end else begin
      if (bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.data_valid) begin
        if (run_cnt == 0 && seen_block) gaps.push_back(low_cnt);
        run_cnt++;
        out_ck.push_back(bus.ck);
        out_ckp.push_back(bus.ckp);
        out_len.push_back(bus.length);
      end else begin
        if (run_cnt != 0) begin
          runs.push_back(run_cnt);
          seen_block = 1'b1;
          low_cnt    = 0;
        end
        run_cnt = 0;
        low_cnt++;
        if (bus.ck || bus.ckp) idle_nz++;
      end
    end
  end

  // pi(j) = (f1*j + f2*j^2) mod K, straight from the QPP definition.
  function automatic int qpp(input int j, input bit lng);
    longint k, f1, f2, jj;
    k  = lng ? 6144 : 1056;
    f1 = lng ? 263 : 17;
    f2 = lng ? 480 : 66;
    jj = longint'(j);
    return int'((f1 * jj + f2 * jj * jj) % k);
  endfunction

  function automatic int stream_errors();
    int e    = 0;
    int base = 0;
    if (out_ck.size() != m_bits.size()) return -1;
    for (int b = 0; b < m_k.size(); b++) begin
      for (int j = 0; j < m_k[b]; j++) begin
        if (out_ck[base+j] !== m_bits[base+j]) e++;
        if (out_ckp[base+j] !== m_bits[base+qpp(j, m_len[b])]) e++;
        if (out_len[base+j] !== m_len[b]) e++;
      end
      base += m_k[b];
    end
    return e;
  endfunction

  function automatic int runs_errors();
    int e = 0;
    if (runs.size() != m_k.size()) return -1;
    for (int b = 0; b < runs.size(); b++) if (runs[b] != m_k[b]) e++;
    return e;
  endfunction

  function automatic int gap_errors();
    int e = 0;
    if (gaps.size() != m_k.size() - 1) return -1;
    for (int b = 0; b < gaps.size(); b++) if (gaps[b] != GAP + 1) e++;
    return e;
  endfunction

  task automatic clear_all();
    m_bits.delete(); m_k.delete(); m_len.delete();
    out_ck.delete(); out_ckp.delete(); out_len.delete();
    runs.delete(); gaps.delete();
    stall_cnt  = 0;
    idle_nz    = 0;
    seen_block = 1'b0;
  endtask

  task automatic rand_bits();
    for (int i = 0; i < K_L; i++) wbits[i] = 1'($urandom);
  endtask

  task automatic zero_bits();
    for (int i = 0; i < K_L; i++) wbits[i] = 1'b0;
  endtask

  task automatic send_block(input bit lng, input bit scramble, input bit drop_after);
    int k;
    k = lng ? K_L : K_S;
    m_k.push_back(k);
    m_len.push_back(lng);
    for (int i = 0; i < k; i++) begin
      int waited;
      bit acc;
      waited = 0;
      m_bits.push_back(wbits[i]);
      bus.data_in   = wbits[i];
      bus.in_valid  = 1'b1;
      bus.in_length = (i == 0) ? lng : (scramble ? 1'($urandom) : lng);
      do begin
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        waited++;
        if (waited > 20000) begin
          total++;
          bad++;
          $display("FAIL send_timeout: in_ready low for %0d cycles, required < 20000", waited);
          $display("test done: total=%0d bad=%0d", total, bad);
          $fatal(1, "writer stalled");
        end
      end while (!acc);
    end
    if (drop_after) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    int t;
    t = 0;
    while (out_ck.size() < n && t < 40000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (GAP + 3) @(posedge clk);
    #1;
    ok = (out_ck.size() == n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.data_valid, bus.ck, bus.ckp, bus.length} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: dv/ck/ckp/len=%b, required 0000",
               {bus.data_valid, bus.ck, bus.ckp, bus.length});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_alternating();
    bit a, b, ok;
    int e;
    clear_all();
    for (int i = 0; i < K_S; i++) wbits[i] = i[0];
    send_block(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    a = bus.data_valid;
    @(posedge clk);
    #1;
    b = bus.data_valid;
    total++;
    if ({a, b} !== 2'b01) begin
      bad++;
      $display("FAIL latency: dv after 1/2 edges=%b%b, required 01", a, b);
    end
    wait_out(K_S, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL alt_count: got %0d bits, required %0d", out_ck.size(), K_S);
    end
    e = stream_errors();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL alt_stream: errors=%0d, required 0", e);
    end
    e = runs_errors();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL alt_runs: errors=%0d, required 0", e);
    end
    total++;
    if (out_ckp.size() < 4 || {out_ckp[0], out_ckp[1], out_ckp[2]} !== 3'b010 ||
        {out_ck[0], out_ck[1], out_ck[2], out_ck[3]} !== 4'b0101) begin
      bad++;
      $display("FAIL alt_head: ckp/ck head wrong (size %0d), required ckp 010 ck 0101",
               out_ckp.size());
    end
    total++;
    if (idle_nz !== 0) begin
      bad++;
      $display("FAIL idle_zero: %0d idle cycles with ck/ckp set, required 0", idle_nz);
    end
  endtask

  task automatic test_long_single();
    bit ok;
    int e, nckp0, jckp0, nck0, jck0, nckp1, jckp1, nck1, jck1;
    clear_all();
    zero_bits();
    wbits[743] = 1'b1;
    send_block(1'b1, 1'b0, 1'b0);
    wbits[743]  = 1'b0;
    wbits[2446] = 1'b1;
    send_block(1'b1, 1'b0, 1'b1);
    wait_out(2 * K_L, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL long_count: got %0d bits, required %0d", out_ck.size(), 2 * K_L);
    end
    e = stream_errors();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL long_stream: errors=%0d, required 0", e);
    end
    nckp0 = 0; jckp0 = -1; nck0 = 0; jck0 = -1;
    nckp1 = 0; jckp1 = -1; nck1 = 0; jck1 = -1;
    for (int j = 0; j < K_L && ok; j++) begin
      if (out_ckp[j]) begin nckp0++; jckp0 = j; end
      if (out_ck[j]) begin nck0++; jck0 = j; end
      if (out_ckp[K_L+j]) begin nckp1++; jckp1 = j; end
      if (out_ck[K_L+j]) begin nck1++; jck1 = j; end
    end
    total++;
    if (nckp0 !== 1 || jckp0 !== 1 || nck0 !== 1 || jck0 !== 743) begin
      bad++;
      $display("FAIL long_743: ckp n=%0d at %0d, ck n=%0d at %0d, required 1@1 and 1@743",
               nckp0, jckp0, nck0, jck0);
    end
    total++;
    if (nckp1 !== 1 || jckp1 !== 2 || nck1 !== 1 || jck1 !== 2446) begin
      bad++;
      $display("FAIL long_2446: ckp n=%0d at %0d, ck n=%0d at %0d, required 1@2 and 1@2446",
               nckp1, jckp1, nck1, jck1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int e;
    clear_all();
    for (int b = 0; b < 3; b++) begin
      rand_bits();
      send_block(1'b0, 1'b0, b == 2);
    end
    wait_out(3 * K_S, ok);
    e = stream_errors();
    total++;
    if (!ok || e !== 0) begin
      bad++;
      $display("FAIL b2b_stream: bits=%0d errors=%0d, required %0d and 0", out_ck.size(), e,
               3 * K_S);
    end
    e = runs_errors();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL b2b_runs: errors=%0d, required 0", e);
    end
    e = gap_errors();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL b2b_gaps: errors=%0d, required 0", e);
    end
    // Block 2 fills one cycle before block 1's last read frees its bank.
    total++;
    if (stall_cnt !== 1) begin
      bad++;
      $display("FAIL b2b_stall: in_ready low for %0d cycles, required 1", stall_cnt);
    end
  endtask

  task automatic test_mixed();
    bit ok;
    int e, nchg, first_chg;
    clear_all();
    rand_bits();
    send_block(1'b1, 1'b1, 1'b0);
    rand_bits();
    send_block(1'b0, 1'b1, 1'b1);
    wait_out(K_L + K_S, ok);
    e = stream_errors();
    total++;
    if (!ok || e !== 0) begin
      bad++;
      $display("FAIL mixed_stream: bits=%0d errors=%0d, required %0d and 0", out_ck.size(), e,
               K_L + K_S);
    end
    e = runs_errors();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL mixed_runs: errors=%0d, required 0", e);
    end
    e = gap_errors();
    total++;
    if (e !== 0) begin
      bad++;
      $display("FAIL mixed_gap: errors=%0d, required 0", e);
    end
    nchg = 0;
    first_chg = -1;
    for (int j = 1; j < out_len.size(); j++) begin
      if (out_len[j] != out_len[j-1]) begin
        nchg++;
        if (first_chg < 0) first_chg = j;
      end
    end
    total++;
    if (nchg !== 1 || first_chg !== K_L) begin
      bad++;
      $display("FAIL mixed_length: %0d changes, first at %0d, required 1 at %0d", nchg,
               first_chg, K_L);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e;
    clear_all();
    rand_bits();
    for (int i = 0; i < 500; i++) begin
      bus.data_in   = wbits[i];
      bus.in_valid  = 1'b1;
      bus.in_length = 1'b0;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.data_valid, bus.ck, bus.ckp, bus.in_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL rst_mid_write: dv/ck/ckp/rdy=%b, required 0001",
               {bus.data_valid, bus.ck, bus.ckp, bus.in_ready});
    end
    rst = 1'b0;
    for (int i = 0; i < K_L; i++) wbits[i] = 1'b1;
    send_block(1'b0, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    total++;
    if ({bus.data_valid, bus.ck, bus.ckp} !== 3'b111) begin
      bad++;
      $display("FAIL mid_read_busy: dv/ck/ckp=%b, required 111",
               {bus.data_valid, bus.ck, bus.ckp});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus.data_valid, bus.ck, bus.ckp, bus.in_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL rst_mid_read: dv/ck/ckp/rdy=%b, required 0001",
               {bus.data_valid, bus.ck, bus.ckp, bus.in_ready});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_all();
    rand_bits();
    send_block(1'b0, 1'b0, 1'b1);
    wait_out(K_S, ok);
    e = stream_errors();
    total++;
    if (!ok || e !== 0 || runs_errors() !== 0) begin
      bad++;
      $display("FAIL post_reset_block: bits=%0d errors=%0d, required %0d and 0",
               out_ck.size(), e, K_S);
    end
  endtask

  task automatic test_permutation();
    bit ok;
    int e, hits, hitj;
    int pos [8];
    pos[0] = 0;
    pos[1] = 1;
    pos[2] = K_S - 1;
    for (int i = 3; i < 8; i++) pos[i] = int'($urandom_range(K_S - 2, 2));
    clear_all();
    for (int b = 0; b < 8; b++) begin
      zero_bits();
      wbits[pos[b]] = 1'b1;
      send_block(1'b0, 1'b0, b == 7);
    end
    wait_out(8 * K_S, ok);
    e = stream_errors();
    total++;
    if (!ok || e !== 0) begin
      bad++;
      $display("FAIL perm_stream: bits=%0d errors=%0d, required %0d and 0", out_ck.size(), e,
               8 * K_S);
    end
    e = gap_errors();
    total++;
    if (e !== 0 || runs_errors() !== 0) begin
      bad++;
      $display("FAIL perm_framing: gap errors=%0d, required 0", e);
    end
    for (int b = 0; b < 8 && ok; b++) begin
      hits = 0;
      hitj = -1;
      for (int j = 0; j < K_S; j++) begin
        if (out_ckp[b*K_S+j]) begin
          hits++;
          hitj = j;
        end
      end
      total++;
      if (hits !== 1 || qpp(hitj, 1'b0) !== pos[b]) begin
        bad++;
        $display("FAIL perm_p%0d: %0d ckp hits, last at j=%0d, required one j with pi(j)=%0d",
                 pos[b], hits, hitj, pos[b]);
      end
    end
  endtask

  initial begin
    bus.data_in   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_length = 1'b0;
    test_reset();
    test_alternating();
    test_long_single();
    test_back_to_back();
    test_mixed();
    test_reset_mid();
    test_permutation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
